instr_fetch_unit: RTL and testbench

- Fetch stage of the single-issue RISC-V core.
- Keeps the PC, issues one instruction-memory read at a time, and presents the fetched word to decode over a valid/ready handshake.
- Exposes instr[6:0] as the opcode feeding the control unit.
- Accepts branch/jump redirects from execute and discards stale fetches.

---
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time and
// hands the fetched word to decode, dropping responses made stale by redirects.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               enable,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [6:0]         opcode,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [2:0]         dbg_state
);

    // Handshake: a word moves to decode in any cycle where instr_valid and
    // instr_ready are both high; instr/instr_pc stay stable until then.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  redirect_tgt;
    state_t             resume_state;

    assign redirect_tgt = redirect_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    assign resume_state = enable ? REQ : IDLE;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = REQ;
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = resume_state;
                end
            end
            DRAIN: begin
                if (imem_rvalid) state_d = resume_state;
            end
            default: state_d = IDLE;
        endcase

        // A redirect wins over the normal flow; any word in flight becomes stale.
        if (redirect_valid) begin
            pc_d = redirect_tgt;
            case (state_q)
                IDLE: state_d = IDLE;
                REQ:  state_d = DRAIN;
                WAIT: begin
                    instr_d    = instr_q;
                    instr_pc_d = instr_pc_q;
                    state_d    = imem_rvalid ? resume_state : DRAIN;
                end
                HOLD: state_d = resume_state;
                default: ;
            endcase
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = (state_q == REQ) ? pc_q : '0;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = instr_q[6:0];
    assign fetch_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are sampled on
// the falling clock edge, so every posedge sees settled stimulus.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [6:0]  opcode;
    logic [31:0] fetch_count;
    logic [2:0]  dbg_state;

    // Second instance parked at the top of the address space.
    logic        w_arst_n;
    logic        w_enable;
    logic        w_imem_req;
    logic [63:0] w_imem_addr;
    logic        w_imem_rvalid;
    logic [31:0] w_imem_rdata;
    logic        w_redirect_valid;
    logic [63:0] w_redirect_pc;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic [31:0] w_instr;
    logic [63:0] w_instr_pc;
    logic [6:0]  w_opcode;
    logic [31:0] w_fetch_count;
    logic [2:0]  w_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
        .fetch_count(fetch_count), .dbg_state(dbg_state)
    );

    instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .arst_n(w_arst_n), .enable(w_enable),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .instr(w_instr), .instr_pc(w_instr_pc), .opcode(w_opcode),
        .fetch_count(w_fetch_count), .dbg_state(w_dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Called with the REQ cycle just observed; returns with HOLD observed.
    task automatic fetch_one(input logic [31:0] data, input int lat);
        cyc();
        for (int i = 0; i < lat - 1; i++) cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic check_delivery(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            check(tag, {32'd0, instr}, {32'd0, exp_q.pop_front()});
        end
    endtask

    initial begin
        arst_n = 1'b0; enable = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        w_arst_n = 1'b0; w_enable = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_instr_ready = 1'b0;

        cyc();
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_count", fetch_count, 0);

        // Basic fetch with a 1-cycle memory
        arst_n = 1'b1; enable = 1'b1; instr_ready = 1'b1;
        cyc();
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, 64'h0);
        exp_q.push_back(32'h0000_0013);
        fetch_one(32'h0000_0013, 1);
        check("t1_valid", instr_valid, 1);
        check_delivery("t1_instr");
        check("t1_pc", instr_pc, 64'h0);
        check("t1_opcode", opcode, 7'h13);
        cyc();
        check("t1_req2", imem_req, 1);
        check("t1_addr2", imem_addr, 64'h4);
        check("t1_count", fetch_count, 1);
        check("t1_valid_drop", instr_valid, 0);

        // Decode stalls for five cycles
        instr_ready = 1'b0;
        exp_q.push_back(32'h0050_0093);
        fetch_one(32'h0050_0093, 1);
        check_delivery("t2_instr");
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_hold_valid", instr_valid, 1);
            check("t2_hold_instr", instr, 32'h0050_0093);
            check("t2_hold_pc", instr_pc, 64'h4);
            check("t2_hold_noreq", imem_req, 0);
        end
        instr_ready = 1'b1;
        cyc();
        check("t2_count", fetch_count, 2);
        check("t2_req", imem_req, 1);
        check("t2_addr", imem_addr, 64'h8);

        // Redirect while waiting on a 3-cycle memory
        cyc();
        check("t3_wait", dbg_state, 3'd2);
        redirect_valid = 1'b1; redirect_pc = 64'h103;
        cyc();
        redirect_valid = 1'b0; redirect_pc = '0;
        check("t3_drain", dbg_state, 3'd4);
        check("t3_noreq", imem_req, 0);
        cyc();
        check("t3_noreq2", imem_req, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0; imem_rdata = '0;
        check("t3_stale_valid", instr_valid, 0);
        check("t3_req", imem_req, 1);
        check("t3_addr", imem_addr, 64'h100);
        exp_q.push_back(32'h0020_8033);
        fetch_one(32'h0020_8033, 3);
        check_delivery("t3_instr");
        check("t3_pc", instr_pc, 64'h100);
        check("t3_opcode", opcode, 7'h33);

        // Redirect during handshake in HOLD
        redirect_valid = 1'b1; redirect_pc = 64'h200;
        cyc();
        redirect_valid = 1'b0; redirect_pc = '0;
        check("t4_count", fetch_count, 3);
        check("t4_valid", instr_valid, 0);
        check("t4_req", imem_req, 1);
        check("t4_addr", imem_addr, 64'h200);

        // Async reset in WAIT, then a stale response while idle
        cyc();
        enable = 1'b0;
        arst_n = 1'b0;
        #1;
        check("t5_req", imem_req, 0);
        check("t5_addr", imem_addr, 0);
        check("t5_valid", instr_valid, 0);
        check("t5_instr", instr, 0);
        check("t5_pc", instr_pc, 0);
        check("t5_count", fetch_count, 0);
        cyc();
        arst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
        cyc();
        imem_rvalid = 1'b0; imem_rdata = '0;
        check("t5_idle_valid", instr_valid, 0);
        check("t5_idle_req", imem_req, 0);
        check("t5_idle_instr", instr, 0);
        enable = 1'b1;
        cyc();
        check("t5_req_first", imem_req, 1);
        check("t5_addr_first", imem_addr, 64'h0);

        // Enable dropped at handshake parks in IDLE; redirect in IDLE moves the PC
        exp_q.push_back(32'h0000_0067);
        fetch_one(32'h0000_0067, 2);
        check_delivery("t6_instr");
        enable = 1'b0;
        cyc();
        check("t6_count", fetch_count, 1);
        check("t6_idle", dbg_state, 3'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h47;
        cyc();
        redirect_valid = 1'b0; redirect_pc = '0;
        check("t6_still_idle", imem_req, 0);
        enable = 1'b1;
        cyc();
        check("t6_req", imem_req, 1);
        check("t6_addr", imem_addr, 64'h44);

        // PC wraps at the top of the address space
        w_arst_n = 1'b1; w_enable = 1'b1; w_instr_ready = 1'b1;
        cyc();
        check("t7_req", w_imem_req, 1);
        check("t7_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        w_imem_rvalid = 1'b1; w_imem_rdata = 32'h0000_006F;
        cyc();
        w_imem_rvalid = 1'b0; w_imem_rdata = '0;
        check("t7_valid", w_instr_valid, 1);
        check("t7_pc", w_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        check("t7_req2", w_imem_req, 1);
        check("t7_wrap_addr", w_imem_addr, 64'h0);
        check("t7_count", w_fetch_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
